// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 default timing, colour-bar constants and the fetch/delay tap type.
// The tap carries a bar index only when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // {R,G,B} of bar k is simply the bits of k: black, blue, green, cyan, red, magenta, yellow, white
    localparam logic [2:0] BAR_RGB [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                           3'b100, 3'b101, 3'b110, 3'b111};

    // One raster position as it travels from the fetch stage to the output stage
    typedef struct packed {
        logic       req;
        logic       hs;
        logic       vs;
        logic       first;
`ifdef VGA_TEST_PATTERN_EN
        logic [2:0] bar;
`endif
    } vga_tap_t;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (H or V); counts active, front porch, sync, back porch.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         act,
    output logic         sync
);

    localparam int           TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

    if (TOTAL >= 2 ** W) begin : g_width_chk
        $error("vga_axis_counter: total count does not fit in W bits");
    end

    // wrap is qualified by advance so the next axis can use it directly as its advance
    assign wrap = advance && (count == LAST);
    assign act  = count < ACT_END;
    assign sync = (count >= SYNC_BEG) && (count < SYNC_END);

    // Position counter, steps only when advanced
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (advance)
            count <= wrap ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster generator with pixel pre-fetch and FETCH_LAT-deep alignment delay.
// Optional macro VGA_TEST_PATTERN_EN adds pattern_sel and an internal 8-bar colour pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int COLOR_W   = 1,
    parameter int FETCH_LAT = 1,
    parameter int X_W       = 10,
    parameter int Y_W       = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [3*COLOR_W-1:0] pix_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 pattern_sel,
`endif
    output logic                 req,
    output logic [X_W-1:0]       req_x,
    output logic [Y_W-1:0]       req_y,
    output logic [3*COLOR_W-1:0] color,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 active,
    output logic                 frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (FETCH_LAT < 1 || FETCH_LAT > 8) begin : g_lat_chk
        $error("vga_timing_gen: FETCH_LAT must be in 1..8");
    end
    if (H_TOTAL >= 2 ** X_W) begin : g_h_chk
        $error("vga_timing_gen: H_TOTAL does not fit in X_W bits");
    end
    if (V_TOTAL >= 2 ** Y_W) begin : g_v_chk
        $error("vga_timing_gen: V_TOTAL does not fit in Y_W bits");
    end

    logic [X_W-1:0] hcnt;
    logic [Y_W-1:0] vcnt;
    logic           h_wrap, h_act, h_sync;
    logic           v_wrap_unused, v_act, v_sync;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (X_W)
    ) u_h (
        .clk     (clk),
        .reset   (reset),
        .advance (en),
        .count   (hcnt),
        .wrap    (h_wrap),
        .act     (h_act),
        .sync    (h_sync)
    );

    // Lines advance on the enabled cycle that ends a line, so both axes wrap together
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (Y_W)
    ) u_v (
        .clk     (clk),
        .reset   (reset),
        .advance (h_wrap),
        .count   (vcnt),
        .wrap    (v_wrap_unused),
        .act     (v_act),
        .sync    (v_sync)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [X_W-1:0] BAR_W = X_W'(H_ACTIVE / 8);
    if (H_ACTIVE < 8) begin : g_bar_chk
        $error("vga_timing_gen: H_ACTIVE too small for 8 colour bars");
    end
`endif

    vga_tap_t fetch_d, fetch_q;
    vga_tap_t dl [FETCH_LAT];
    vga_tap_t tap;

    // Decode the current counter position into a tap
    always_comb begin
        fetch_d       = '0;
        fetch_d.req   = h_act && v_act;
        fetch_d.hs    = h_sync;
        fetch_d.vs    = v_sync;
        fetch_d.first = (hcnt == '0) && (vcnt == '0);
`ifdef VGA_TEST_PATTERN_EN
        fetch_d.bar   = 3'(hcnt / BAR_W);
`endif
    end

    // Fetch stage: register the request and its coordinates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_q <= '0;
            req_x   <= '0;
            req_y   <= '0;
        end else if (en) begin
            fetch_q <= fetch_d;
            req_x   <= fetch_d.req ? hcnt : '0;
            req_y   <= fetch_d.req ? vcnt : '0;
        end
    end

    assign req = fetch_q.req;

    // Delay line matching the frame-buffer read latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FETCH_LAT; i++) dl[i] <= '0;
        end else if (en) begin
            dl[0] <= fetch_q;
            for (int i = 1; i < FETCH_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    assign tap = dl[FETCH_LAT-1];

    logic [3*COLOR_W-1:0] color_d;

`ifdef VGA_TEST_PATTERN_EN
    logic       pat_mode;
    logic       pat_now;
    logic [2:0] bar_rgb;

    // Source selection latches only on the first pixel of a frame so frames never mix sources
    always_comb begin
        pat_now = tap.first ? pattern_sel : pat_mode;
        bar_rgb = BAR_RGB[tap.bar];
        color_d = !tap.req ? '0
                : pat_now  ? {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}}
                :            pix_in;
    end

    // Remember the source chosen at the last frame start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pat_mode <= 1'b0;
        else if (en)
            pat_mode <= pat_now;
    end
`else
    // Pixel data passes only inside the active area
    always_comb begin
        color_d = tap.req ? pix_in : '0;
    end
`endif

    // Output stage: pins toward the DAC and sync connectors
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            color       <= '0;
            active      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else if (en) begin
            color       <= color_d;
            active      <= tap.req;
            hsync       <= tap.hs ? HS_POL : ~HS_POL;
            vsync       <= tap.vs ? VS_POL : ~VS_POL;
            frame_start <= tap.first;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a default 640x480 instance and a small FETCH_LAT=3 instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic toggle;
    logic psel;
    int   edges = 0;
    int   base  = 0;
    int   checks = 0;
    int   errors = 0;

    logic [2:0] pix_a, color_a;
    logic [9:0] req_x_a, req_y_a;
    logic       req_a, hs_a, vs_a, act_a, fs_a;

    logic [2:0] pix_b, color_b, s1_b, s2_b;
    logic [5:0] req_x_b, req_y_b;
    logic       req_b, hs_b, vs_b, act_b, fs_b;

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) en = !toggle || ((edges - base) % 2 == 0);

    // Frame-buffer models: answer with req_x[2:0] after FETCH_LAT enabled cycles
    always @(posedge clk) if (en) pix_a <= req_x_a[2:0];
    always @(posedge clk) if (en) begin
        s1_b  <= req_x_b[2:0];
        s2_b  <= s1_b;
        pix_b <= s2_b;
    end

    vga_timing_gen u_a (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pix_in      (pix_a),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel (psel),
`endif
        .req         (req_a),
        .req_x       (req_x_a),
        .req_y       (req_y_a),
        .color       (color_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .active      (act_a),
        .frame_start (fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .FETCH_LAT (3), .X_W (6), .Y_W (6)
    ) u_b (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pix_in      (pix_b),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel (psel),
`endif
        .req         (req_b),
        .req_x       (req_x_b),
        .req_y       (req_y_b),
        .color       (color_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .active      (act_b),
        .frame_start (fs_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic goto(input int n);
        while (edges - base < n) @(negedge clk);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        reset = 1'b1;
        base  = edges;
        en    = 1'b1;
    endtask

    task automatic assert_rst();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; toggle = 1'b0; psel = 1'b0; en = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_hsync_a", int'(hs_a), 1);
        check("rst_vsync_a", int'(vs_a), 1);
        check("rst_color_a", int'(color_a), 0);
        check("rst_req_a", int'(req_a), 0);
        check("rst_active_b", int'(act_b), 0);
        check("rst_hsync_b", int'(hs_b), 1);

        // default 640x480 line timing, FETCH_LAT=1
        release_rst();
        goto(1);   check("a_req0", int'(req_a), 1); check("a_rx0", int'(req_x_a), 0); check("a_ry0", int'(req_y_a), 0);
        goto(2);   check("a_rx1", int'(req_x_a), 1);
        goto(3);   check("a_act_first", int'(act_a), 1); check("a_fs", int'(fs_a), 1);
        goto(4);   check("a_fs_pulse", int'(fs_a), 0);
        goto(640); check("a_req_last", int'(req_a), 1); check("a_rx_last", int'(req_x_a), 639);
        goto(641); check("a_req_fp", int'(req_a), 0); check("a_rx_fp", int'(req_x_a), 0);
        goto(642); check("a_act_last", int'(act_a), 1);
        goto(643); check("a_act_end", int'(act_a), 0);
        goto(658); check("a_hs_before", int'(hs_a), 1);
        goto(659); check("a_hs_start", int'(hs_a), 0);
        goto(700); check("a_vs_line0", int'(vs_a), 1);
        goto(754); check("a_hs_last", int'(hs_a), 0);
        goto(755); check("a_hs_end", int'(hs_a), 1);
        goto(801); check("a_ry_line1", int'(req_y_a), 1);
        goto(802); check("a_act_bp", int'(act_a), 0);
        goto(803); check("a_act_line1", int'(act_a), 1);

        // small raster: H_TOTAL=24, V_TOTAL=15, FETCH_LAT=3, outputs at position+5
        assert_rst();
        check("b_rst_active", int'(act_b), 0);
        release_rst();
        goto(1); check("b_req0", int'(req_b), 1); check("b_rx0", int'(req_x_b), 0);
        for (int n = 0; n < 16; n++) begin
            goto(5 + n);
            check("b_pix_color", int'(color_b), n % 8);
            check("b_pix_active", int'(act_b), 1);
        end
        check("b_fs_off", int'(fs_b), 0);
        goto(21);  check("b_act_fp", int'(act_b), 0); check("b_color_fp", int'(color_b), 0);
        goto(22);  check("b_hs_pre", int'(hs_b), 1);
        goto(23);  check("b_hs_on", int'(hs_b), 0);
        goto(25);  check("b_hs_last", int'(hs_b), 0); check("b_ry1", int'(req_y_b), 1);
        goto(26);  check("b_hs_off", int'(hs_b), 1);
        goto(29);  check("b_act_line1", int'(act_b), 1);
        goto(169); check("b_ry7", int'(req_y_b), 7);
        goto(173); check("b_act_line7", int'(act_b), 1);
        goto(197); check("b_act_line8", int'(act_b), 0);
        goto(244); check("b_vs_pre", int'(vs_b), 1);
        goto(245); check("b_vs_on", int'(vs_b), 0);
        goto(292); check("b_vs_last", int'(vs_b), 0);
        goto(293); check("b_vs_off", int'(vs_b), 1);
        goto(360); check("b_req_end", int'(req_b), 0);
        goto(361); check("b_req_wrap", int'(req_b), 1); check("b_ry_wrap", int'(req_y_b), 0);
        goto(364); check("b_fs_pre", int'(fs_b), 0);
        goto(365); check("b_fs_period", int'(fs_b), 1);

        // en toggling 1,0,1,0: every period doubles, outputs hold on en=0 cycles
        assert_rst();
        toggle = 1'b1;
        release_rst();
        goto(1);  check("t_rx0", int'(req_x_b), 0);
        goto(2);  check("t_rx0_hold", int'(req_x_b), 0);
        goto(3);  check("t_rx1", int'(req_x_b), 1);
        goto(4);  check("t_rx1_hold", int'(req_x_b), 1);
        goto(9);  check("t_fs", int'(fs_b), 1);
        goto(10); check("t_fs_hold", int'(fs_b), 1);
        goto(11); check("t_fs_off", int'(fs_b), 0);
        goto(15); check("t_color3", int'(color_b), 3);
        goto(16); check("t_color3_hold", int'(color_b), 3);
        goto(44); check("t_hs_pre", int'(hs_b), 1);
        goto(45); check("t_hs_on", int'(hs_b), 0);
        goto(50); check("t_hs_last", int'(hs_b), 0);
        goto(51); check("t_hs_off", int'(hs_b), 1);
        goto(56); check("t_act_bp", int'(act_b), 0);
        goto(57); check("t_act_line1", int'(act_b), 1);
        goto(101);
        assert_rst();
        check("mid_rst_req", int'(req_b), 0);
        check("mid_rst_rx", int'(req_x_b), 0);
        check("mid_rst_active", int'(act_b), 0);
        check("mid_rst_hsync", int'(hs_b), 1);
        release_rst();
        goto(1);  check("r_req0", int'(req_b), 1); check("r_rx0", int'(req_x_b), 0); check("r_ry0", int'(req_y_b), 0);
        goto(9);  check("r_fs", int'(fs_b), 1);
        goto(15); check("r_color3", int'(color_b), 3);
        toggle = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
        // colour bars: BAR_W=2 on the small raster; source switches only at frame start
        assert_rst();
        psel = 1'b1;
        release_rst();
        for (int n = 0; n < 16; n += 2) begin
            goto(5 + n);
            check("p_bar", int'(color_b), n / 2);
        end
        goto(100);
        psel = 1'b0;
        goto(131); check("p_bar_kept", int'(color_b), 3);
        goto(371); check("p_pix_next_frame", int'(color_b), 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
